// File: rtl/rc5_pkg.sv
// Shared definitions for the 16-bit RC5 cipher pair (8-bit half-words, one round).
// Holds the FSM state type, the half-word and rotate widths, and the default
// S-table.
package rc5_pkg;

  localparam int HALF_W = 8;
  localparam int ROT_W  = 3;  // rotate amount is the low 3 bits of a half-word

  // Default key table; the encryptor on the transmit side uses the same words.
  localparam logic [HALF_W-1:0] S0_DEF = 8'h20;  // pre-whitening of A
  localparam logic [HALF_W-1:0] S1_DEF = 8'h10;  // pre-whitening of B
  localparam logic [HALF_W-1:0] S2_DEF = 8'hFF;  // round key for A
  localparam logic [HALF_W-1:0] S3_DEF = 8'hFF;  // round key for B

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RND_B = 3'd1,
    RND_A = 3'd2,
    UNWHT = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/rc5_rotr8.sv
// Combinational 8-bit rotate right.
//   x : value to rotate
//   n : rotate amount (0..7); n = 0 passes x through unchanged
//   y : rotated result
module rc5_rotr8
  import rc5_pkg::*;
(
  input  logic [HALF_W-1:0] x,
  input  logic [ROT_W-1:0]  n,
  output logic [HALF_W-1:0] y
);

  logic [2*HALF_W-1:0] doubled;

  // Shifting two back-to-back copies right leaves the rotated value in the low half.
  assign doubled = {x, x} >> n;
  assign y       = doubled[HALF_W-1:0];

endmodule

// File: rtl/rc5_dec_16bit.sv
// 16-bit RC5 decryptor: one round, 4-entry S-table, 8-bit half-words.
// A 5-state FSM recovers the plaintext from the ciphertext in 4 cycles and
// accepts a new job every 5 cycles.
//   clock     : rising-edge clock
//   reset     : synchronous, active-high
//   dec_start : decryption request, sampled only in IDLE
//   c         : ciphertext, [15:8] = A, [7:0] = B
//   p         : recovered plaintext, [15:8] = A, [7:0] = B
//   dec_done  : p valid; held until the next accepted dec_start
//   busy      : decryption in flight
module rc5_dec_16bit
  import rc5_pkg::*;
#(
  parameter logic [HALF_W-1:0] S0 = S0_DEF,
  parameter logic [HALF_W-1:0] S1 = S1_DEF,
  parameter logic [HALF_W-1:0] S2 = S2_DEF,
  parameter logic [HALF_W-1:0] S3 = S3_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                dec_start,
  input  logic [2*HALF_W-1:0] c,
  output logic [2*HALF_W-1:0] p,
  output logic                dec_done,
  output logic                busy
);

  state_t              state_q, state_d;
  logic [HALF_W-1:0]   a_q, a_d, b_q, b_d;
  logic [2*HALF_W-1:0] p_d;
  logic                done_d, busy_d;

  logic [HALF_W-1:0]   b_sub, b_rot, a_sub, a_rot;

  assign b_sub = b_q - S3;
  assign a_sub = a_q - S2;

  // RND_B undoes the B half of the round using the ciphertext A as rotate amount.
  rc5_rotr8 u_rotr_b (
    .x (b_sub),
    .n (a_q[ROT_W-1:0]),
    .y (b_rot)
  );

  // RND_A runs one cycle later, so b_q already holds the recovered B here.
  rc5_rotr8 u_rotr_a (
    .x (a_sub),
    .n (b_q[ROT_W-1:0]),
    .y (a_rot)
  );

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p;
    done_d  = dec_done;
    busy_d  = busy;
    case (state_q)
      IDLE: begin
        if (dec_start) begin
          a_d     = c[2*HALF_W-1:HALF_W];
          b_d     = c[HALF_W-1:0];
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = RND_B;
        end
      end
      RND_B: begin
        b_d     = b_rot ^ a_q;
        state_d = RND_A;
      end
      RND_A: begin
        a_d     = a_rot ^ b_q;
        state_d = UNWHT;
      end
      UNWHT: begin
        a_d     = a_q - S0;
        b_d     = b_q - S1;
        state_d = DONE;
      end
      DONE: begin
        p_d     = {a_q, b_q};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      p        <= '0;
      dec_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p        <= p_d;
      dec_done <= done_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_rc5_dec_16bit.sv
// Self-checking bench for rc5_dec_16bit. Jobs issued by the driver push their
// expected plaintext and accept cycle into a scoreboard queue; a monitor pops
// and compares on every rising dec_done. Random plaintexts are encrypted by a
// reference encryptor and fed in, so the expected output is the original text.
module tb_rc5_dec_16bit;

  typedef struct {
    logic [15:0] exp_p;
    int          acc_cyc;
  } job_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        dec_start;
  logic [15:0] c;
  logic [15:0] p;
  logic        dec_done;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  job_t sb[$];
  logic prev_done = 1'b0;

  rc5_dec_16bit dut (
    .clock     (clock),
    .reset     (reset),
    .dec_start (dec_start),
    .c         (c),
    .p         (p),
    .dec_done  (dec_done),
    .busy      (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference cipher written straight from the RC5 round definition.
  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    int k = n % 8;
    return (k == 0) ? x : 8'((x << k) | (x >> (8 - k)));
  endfunction

  function automatic logic [7:0] rotr(input logic [7:0] x, input int n);
    int k = n % 8;
    return (k == 0) ? x : 8'((x >> k) | (x << (8 - k)));
  endfunction

  function automatic logic [15:0] enc_ref(input logic [15:0] pt);
    logic [7:0] a, b;
    a = pt[15:8] + 8'h20;
    b = pt[7:0]  + 8'h10;
    a = rotl(a ^ b, int'(b)) + 8'hFF;
    b = rotl(b ^ a, int'(a)) + 8'hFF;
    return {a, b};
  endfunction

  function automatic logic [15:0] dec_ref(input logic [15:0] ct);
    logic [7:0] a, b;
    a = ct[15:8];
    b = ct[7:0];
    b = rotr(b - 8'hFF, int'(a)) ^ a;
    a = rotr(a - 8'hFF, int'(b)) ^ b;
    return {a - 8'h20, b - 8'h10};
  endfunction

  // Monitor: one scoreboard entry per rising dec_done, latency fixed at 4.
  always @(negedge clock) begin
    if (!reset && dec_done && !prev_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: dec_done rose with no job pending (cycle %0d)", cyc);
      end else begin
        job_t j;
        j = sb.pop_front();
        check("p", p, j.exp_p);
        check("latency", cyc - j.acc_cyc, 4);
      end
    end
    prev_done <= dec_done;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic wait_drained();
    int n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  // Issue a one-cycle start pulse from IDLE, then scramble c to show it is
  // only sampled at the accept edge.
  task automatic issue(input logic [15:0] ct, input logic [15:0] exp);
    wait_idle();
    c         = ct;
    dec_start = 1'b1;
    sb.push_back('{exp_p: exp, acc_cyc: cyc + 1});
    @(negedge clock);
    dec_start = 1'b0;
    c         = 16'($urandom);
  endtask

  initial begin
    int last_acc;

    reset     = 1'b1;
    dec_start = 1'b0;
    c         = 16'h0;
    repeat (3) @(negedge clock);
    check("reset_p", p, 16'h0000);
    check("reset_done", dec_done, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    @(negedge clock);

    // Zero-rotate vector with busy/done timing observed cycle by cycle.
    c         = 16'h2F9E;
    dec_start = 1'b1;
    sb.push_back('{exp_p: 16'h0000, acc_cyc: cyc + 1});
    @(negedge clock);
    dec_start = 1'b0;
    c         = 16'hA5A5;
    for (int i = 0; i < 4; i++) begin
      check("busy_inflight", busy, 1);
      check("done_inflight", dec_done, 0);
      @(negedge clock);
    end
    check("busy_after", busy, 0);
    check("done_after", dec_done, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("done_hold", dec_done, 1);
      check("p_hold", p, 16'h0000);
    end

    // Both rotate paths non-trivial, then all-ones for subtract wrap.
    issue(16'h6687, 16'h1234);
    wait_drained();
    issue(16'hFFFF, dec_ref(16'hFFFF));
    wait_drained();

    // A start during RND_A must be ignored.
    issue(16'h6687, 16'h1234);
    @(negedge clock);
    c         = 16'h2F9E;
    dec_start = 1'b1;
    @(negedge clock);
    dec_start = 1'b0;
    wait_drained();
    check("p_ignored", p, 16'h1234);
    issue(16'h2F9E, 16'h0000);
    wait_drained();

    // Reset during UNWHT discards the job.
    issue(16'h6687, 16'h1234);
    wait_drained();
    issue(16'h2F9E, 16'h0000);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    void'(sb.pop_back());
    check("midreset_p", p, 16'h0000);
    check("midreset_done", dec_done, 0);
    check("midreset_busy", busy, 0);
    repeat (10) @(negedge clock);
    check("midreset_quiet", dec_done, 0);
    issue(16'h6687, 16'h1234);
    wait_drained();

    // Loopback with dec_start held high: one accept every 5 cycles.
    dec_start = 1'b1;
    last_acc  = -1;
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] pt;
      pt = 16'($urandom);
      wait_idle();
      c = enc_ref(pt);
      sb.push_back('{exp_p: pt, acc_cyc: cyc + 1});
      if (last_acc >= 0) check("throughput", cyc + 1 - last_acc, 5);
      last_acc = cyc + 1;
      @(negedge clock);
      c = 16'($urandom);
    end
    dec_start = 1'b0;
    wait_drained();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
